// File: rtl/card_if.sv
// Transaction link between a vending machine (master) and the card authorizer (slave).
interface card_if #(
  parameter int BAL_W = 8
);
  logic             REQ;
  logic [2:0]       COST;
  logic             VEND;
  logic             FAILED_TRAN;
  logic             TOPUP;
  logic             VALID_TRAN;
  logic             DECLINED;
  logic             BUSY;
  logic [BAL_W-1:0] BALANCE;

  modport master (
    output REQ, COST, VEND, FAILED_TRAN, TOPUP,
    input  VALID_TRAN, DECLINED, BUSY, BALANCE
  );

  modport slave (
    input  REQ, COST, VEND, FAILED_TRAN, TOPUP,
    output VALID_TRAN, DECLINED, BUSY, BALANCE
  );
endinterface

// File: rtl/card_authorizer.sv
// Purpose: authorizes charge requests against a card balance, holds grants until vend/abort/timeout.
// Latency: grant/decline registered AUTH_LATENCY edges after REQ; BALANCE updates one edge after VEND/TOPUP.
// Backpressure: none; REQ outside IDLE is dropped, BUSY tells the requester when a new REQ will be taken.
module card_authorizer #(
  parameter int BAL_W        = 8,
  parameter int INIT_BALANCE = 20,
  parameter int AUTH_LATENCY = 2,
  parameter int HOLD_TIMEOUT = 8,
  parameter int TOPUP_AMT    = 10
) (
  input logic   CLK,
  input logic   RESET_N,
  card_if.slave bus
);

  localparam int LAT_W = (AUTH_LATENCY > 1) ? $clog2(AUTH_LATENCY) : 1;
  localparam int TMR_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [2:0]       amt, amt_nxt;
  logic [LAT_W-1:0] lat, lat_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [BAL_W-1:0] bal, bal_nxt;
  logic             valid_q, valid_nxt;
  logic             decl_q, decl_nxt;
  logic             busy_q, busy_nxt;
  logic [BAL_W:0]   debit;
  logic [BAL_W:0]   bal_sum;

  always_comb begin
    state_nxt = state;
    amt_nxt   = amt;
    lat_nxt   = lat;
    tmr_nxt   = tmr;
    valid_nxt = 1'b0;
    decl_nxt  = 1'b0;
    debit     = '0;

    case (state)
      IDLE: begin
        if (bus.REQ) begin
          amt_nxt   = bus.COST;
          lat_nxt   = LAT_W'(AUTH_LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat == '0) begin
          // Decision uses the committed balance as registered, so top-ups from earlier edges count.
          if (amt != 3'd0 && BAL_W'(amt) <= bal) begin
            valid_nxt = 1'b1;
            tmr_nxt   = TMR_W'(HOLD_TIMEOUT);
            state_nxt = HOLD;
          end else begin
            decl_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          lat_nxt = lat - 1'b1;
        end
      end
      HOLD: begin
        if (bus.VEND) begin
          debit     = (BAL_W+1)'(amt);
          state_nxt = IDLE;
        end else if (bus.FAILED_TRAN) begin
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr - 1'b1;
          if (tmr == TMR_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Debit cannot underflow because the grant checked amt against this same balance.
    bal_sum  = {1'b0, bal} - debit + (bus.TOPUP ? (BAL_W+1)'(TOPUP_AMT) : '0);
    bal_nxt  = bal_sum[BAL_W] ? {BAL_W{1'b1}} : bal_sum[BAL_W-1:0];
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      amt     <= '0;
      lat     <= '0;
      tmr     <= '0;
      bal     <= BAL_W'(INIT_BALANCE);
      valid_q <= 1'b0;
      decl_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      amt     <= amt_nxt;
      lat     <= lat_nxt;
      tmr     <= tmr_nxt;
      bal     <= bal_nxt;
      valid_q <= valid_nxt;
      decl_q  <= decl_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.VALID_TRAN = valid_q;
  assign bus.DECLINED   = decl_q;
  assign bus.BUSY       = busy_q;
  assign bus.BALANCE    = bal;

endmodule

// File: tb/tb_card_authorizer.sv
// Directed bench for card_authorizer with default parameters (latency 2, hold timeout 8, top-up 10).
module tb_card_authorizer;

  logic CLK = 1'b0;
  logic RESET_N;
  int   checks = 0;
  int   errors = 0;
  logic seen;

  card_if #(.BAL_W(8)) bus ();

  card_authorizer #(
    .BAL_W(8), .INIT_BALANCE(20), .AUTH_LATENCY(2), .HOLD_TIMEOUT(8), .TOPUP_AMT(10)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_inputs();
    bus.REQ = 1'b0; bus.COST = 3'd0; bus.VEND = 1'b0;
    bus.FAILED_TRAN = 1'b0; bus.TOPUP = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    clear_inputs();
    #3;
    RESET_N = 1'b1;
    tick();
  endtask

  // Leaves the bench just after the decision edge (k+2).
  task automatic request(input logic [2:0] c);
    bus.REQ = 1'b1; bus.COST = c;
    tick();
    bus.REQ = 1'b0;
    tick();
    tick();
  endtask

  task automatic quiet(input int n, output logic any_pulse);
    any_pulse = 1'b0;
    repeat (n) begin
      tick();
      any_pulse = any_pulse | bus.VALID_TRAN | bus.DECLINED;
    end
  endtask

  task automatic grant_vend(input logic [2:0] c);
    request(c);
    chk1("drain_grant", bus.VALID_TRAN, 1'b1);
    bus.VEND = 1'b1;
    tick();
    bus.VEND = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    clear_inputs();
    #12;
    chk1("rst_valid", bus.VALID_TRAN, 1'b0);
    chk1("rst_declined", bus.DECLINED, 1'b0);
    chk1("rst_busy", bus.BUSY, 1'b0);
    chk8("rst_balance", bus.BALANCE, 8'd20);
    RESET_N = 1'b1;
    tick();

    // Basic grant and commit
    bus.REQ = 1'b1; bus.COST = 3'd3;
    tick();
    bus.REQ = 1'b0;
    chk1("wait_busy", bus.BUSY, 1'b1);
    chk1("wait_no_valid_k", bus.VALID_TRAN, 1'b0);
    tick();
    chk1("wait_no_valid_k1", bus.VALID_TRAN, 1'b0);
    tick();
    chk1("grant_valid", bus.VALID_TRAN, 1'b1);
    chk1("grant_no_decl", bus.DECLINED, 1'b0);
    bus.VEND = 1'b1;
    tick();
    bus.VEND = 1'b0;
    chk1("vend_valid_drop", bus.VALID_TRAN, 1'b0);
    chk1("vend_busy", bus.BUSY, 1'b0);
    chk8("vend_balance", bus.BALANCE, 8'd17);

    // Release on FAILED_TRAN, then zero-cost decline
    do_reset();
    request(3'd4);
    chk1("g4_valid", bus.VALID_TRAN, 1'b1);
    chk1("g4_busy", bus.BUSY, 1'b1);
    tick();
    chk8("hold_no_debit", bus.BALANCE, 8'd20);
    bus.FAILED_TRAN = 1'b1;
    tick();
    bus.FAILED_TRAN = 1'b0;
    chk1("fail_busy", bus.BUSY, 1'b0);
    chk8("fail_balance", bus.BALANCE, 8'd20);
    request(3'd0);
    chk1("zero_declined", bus.DECLINED, 1'b1);
    chk1("zero_no_valid", bus.VALID_TRAN, 1'b0);
    chk1("zero_busy", bus.BUSY, 1'b0);
    tick();
    chk1("zero_decl_drop", bus.DECLINED, 1'b0);

    // Drain to 2, insufficient decline, then top-up during WAIT rescues the grant
    grant_vend(3'd7);
    grant_vend(3'd7);
    grant_vend(3'd4);
    chk8("drain_balance", bus.BALANCE, 8'd2);
    request(3'd5);
    chk1("insuf_declined", bus.DECLINED, 1'b1);
    chk1("insuf_no_valid", bus.VALID_TRAN, 1'b0);
    chk8("insuf_balance", bus.BALANCE, 8'd2);
    tick();
    bus.REQ = 1'b1; bus.COST = 3'd5;
    tick();
    bus.REQ = 1'b0; bus.TOPUP = 1'b1;
    tick();
    bus.TOPUP = 1'b0;
    chk8("topup_wait_balance", bus.BALANCE, 8'd12);
    tick();
    chk1("topup_grant", bus.VALID_TRAN, 1'b1);
    chk1("topup_no_decl", bus.DECLINED, 1'b0);
    bus.FAILED_TRAN = 1'b1;
    tick();
    bus.FAILED_TRAN = 1'b0;
    chk8("topup_release", bus.BALANCE, 8'd12);

    // Hold timeout with REQ hammered during HOLD and on the exit edge
    do_reset();
    request(3'd2);
    chk1("to_grant", bus.VALID_TRAN, 1'b1);
    bus.REQ = 1'b1; bus.COST = 3'd1;
    quiet(7, seen);
    chk1("to_no_pulse_hold", seen, 1'b0);
    chk1("to_busy_before", bus.BUSY, 1'b1);
    tick();
    bus.REQ = 1'b0;
    chk1("to_idle", bus.BUSY, 1'b0);
    chk8("to_balance", bus.BALANCE, 8'd20);
    quiet(3, seen);
    chk1("to_exit_req_ignored", seen, 1'b0);
    chk1("to_still_idle", bus.BUSY, 1'b0);
    request(3'd2);
    chk1("to_next_grant", bus.VALID_TRAN, 1'b1);
    bus.FAILED_TRAN = 1'b1;
    tick();
    bus.FAILED_TRAN = 1'b0;

    // Saturation
    do_reset();
    bus.TOPUP = 1'b1;
    repeat (23) tick();
    chk8("sat_250", bus.BALANCE, 8'd250);
    tick();
    chk8("sat_255", bus.BALANCE, 8'd255);
    tick();
    chk8("sat_hold", bus.BALANCE, 8'd255);
    bus.TOPUP = 1'b0;

    // VEND together with TOPUP, then VEND together with FAILED_TRAN
    do_reset();
    request(3'd3);
    chk1("vt_grant", bus.VALID_TRAN, 1'b1);
    bus.VEND = 1'b1; bus.TOPUP = 1'b1;
    tick();
    clear_inputs();
    chk8("vend_topup", bus.BALANCE, 8'd27);
    chk1("vend_topup_idle", bus.BUSY, 1'b0);
    request(3'd3);
    chk1("vf_grant", bus.VALID_TRAN, 1'b1);
    bus.VEND = 1'b1; bus.FAILED_TRAN = 1'b1;
    tick();
    clear_inputs();
    chk8("vend_wins", bus.BALANCE, 8'd24);

    // Reset mid-WAIT
    bus.REQ = 1'b1; bus.COST = 3'd3;
    tick();
    bus.REQ = 1'b0;
    chk1("mw_busy", bus.BUSY, 1'b1);
    RESET_N = 1'b0;
    #2;
    chk1("mw_rst_busy", bus.BUSY, 1'b0);
    chk8("mw_rst_balance", bus.BALANCE, 8'd20);
    RESET_N = 1'b1;
    quiet(5, seen);
    chk1("mw_no_pulse", seen, 1'b0);
    chk1("mw_idle", bus.BUSY, 1'b0);

    // Reset mid-HOLD, right on the grant pulse
    bus.TOPUP = 1'b1;
    tick();
    bus.TOPUP = 1'b0;
    chk8("mh_topup", bus.BALANCE, 8'd30);
    request(3'd3);
    chk1("mh_grant", bus.VALID_TRAN, 1'b1);
    RESET_N = 1'b0;
    #2;
    chk1("mh_rst_valid", bus.VALID_TRAN, 1'b0);
    chk1("mh_rst_busy", bus.BUSY, 1'b0);
    chk8("mh_rst_balance", bus.BALANCE, 8'd20);
    RESET_N = 1'b1;
    quiet(5, seen);
    chk1("mh_no_pulse", seen, 1'b0);
    chk8("mh_balance_after", bus.BALANCE, 8'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_authorizer.md
Name: card_authorizer

Overview:
Payment-side responder for the vending_machine transaction interface. It receives a charge request carrying COST and answers with a one-cycle VALID_TRAN grant or a DECLINED pulse after a fixed authorization latency. The granted amount is held until the vending machine reports VEND (commit debit), FAILED_TRAN (release) or a hold timeout. It keeps the card balance and supports top-ups.

Parameters:
BAL_W, 8, balance register width
INIT_BALANCE, 20, balance loaded on reset
AUTH_LATENCY, 2, clock edges from REQ sample to grant/decline decision (min 1)
HOLD_TIMEOUT, 8, cycles a granted hold waits for VEND/FAILED_TRAN before release
TOPUP_AMT, 10, amount added per TOPUP pulse

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
REQ  input  1  charge request strobe from the vending machine, one cycle
COST  input  3  charge amount, sampled with REQ
VEND  input  1  vending machine dispensed; commit held amount
FAILED_TRAN  input  1  vending machine aborted; release held amount
TOPUP  input  1  add TOPUP_AMT to balance, one cycle
VALID_TRAN  output  1  grant pulse, one cycle
DECLINED  output  1  decline pulse, one cycle
BUSY  output  1  high in WAIT and HOLD
BALANCE  output  BAL_W  current committed balance

Behaviour:
- Reset (RESET_N low, async): state IDLE; VALID_TRAN=0, DECLINED=0, BUSY=0, BALANCE=INIT_BALANCE, held amount=0, counters=0. Reset mid-WAIT/HOLD drops the request and the hold. No later pulse.
- All outputs registered. VALID_TRAN and DECLINED are never high together and never high for more than one cycle.
- IDLE: REQ sampled high at edge k -> latch COST into amt, load latency counter, go WAIT, BUSY=1 after edge k.
- WAIT: counter decrements each edge. At edge k+AUTH_LATENCY the block decides:
  - amt!=0 and amt<=BALANCE (balance at that edge, including top-ups applied earlier): VALID_TRAN=1 for the following cycle; go HOLD; load hold timer=HOLD_TIMEOUT.
  - otherwise (amt=0 or insufficient): DECLINED=1 for the following cycle; go IDLE; BUSY=0.
- HOLD:
  - VEND high: BALANCE<=BALANCE-amt; go IDLE.
  - FAILED_TRAN high: go IDLE; no debit.
  - VEND and FAILED_TRAN together: VEND wins (debit).
  - Neither: timer decrements. At 0, go IDLE with no debit.
  - VEND/FAILED_TRAN seen in the same cycle as the VALID_TRAN pulse are honoured.
- REQ outside IDLE is ignored. There is no queueing. A REQ on the same edge the block returns to IDLE is also ignored; a new REQ is accepted from the next edge.
- VEND/FAILED_TRAN outside HOLD are ignored.
- Balance arithmetic:
  - Computed in BAL_W+1 bits: next = BALANCE - debit + (TOPUP ? TOPUP_AMT : 0), saturated to 2^BAL_W-1.
  - Debit never underflows, because amt<=BALANCE was checked and TOPUP only adds.
  - TOPUP is accepted in every state, including in the same cycle as a debit.
- A hold does not reduce BALANCE. Only VEND commits the debit.

Test Plan:
- Reset, REQ with COST=3 at edge k -> BUSY=1; VALID_TRAN pulse in the cycle after edge k+2; VEND next cycle -> BALANCE 20->17, BUSY=0.
- Grant COST=4, then FAILED_TRAN in HOLD -> BALANCE stays 20, IDLE; REQ COST=0 -> DECLINED pulse, no VALID_TRAN.
- Drain balance to 2 via grants+VENDs, REQ COST=5 -> DECLINED pulse after latency, BALANCE 2; TOPUP during WAIT of REQ COST=5 at balance 2 -> balance 12 at decision, VALID_TRAN granted.
- Grant COST=2, no VEND/FAILED_TRAN for 8 cycles -> return to IDLE, BALANCE 20, BUSY=0; next REQ accepted normally; REQ pulses during HOLD produce no response.
- Saturation/simultaneity: balance 250 + TOPUP -> 255. In HOLD with amt=3 at balance 20, VEND and TOPUP same cycle -> 27. VEND+FAILED_TRAN same cycle -> debit applied.
- RESET_N low mid-WAIT and mid-HOLD -> outputs 0 immediately, BALANCE=20, no VALID_TRAN/DECLINED pulse after release.
